// File: rtl/pipe_hazard_ctrl.sv
// Bubble/flush scheduler for the 5-stage pipeline: boot purge, load-use/branch hazards, data-memory waits with timeout.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN; otherwise stall_cnt/flush_cnt read 0.
module pipe_hazard_ctrl #(
    parameter int BOOT_FLUSH  = 2,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_D,
    input  logic [4:0]  rs2_D,
    input  logic        use_rs1_D,
    input  logic        use_rs2_D,
    input  logic [4:0]  rd_E,
    input  logic        memread_E,
    input  logic        br_E,
    input  logic        mem_req_M,
    input  logic        mem_ready_M,
    output logic        bubbleF,
    output logic        bubbleD,
    output logic        bubbleE,
    output logic        bubbleM,
    output logic        bubbleW,
    output logic        flushD,
    output logic        flushE,
    output logic        flushM,
    output logic        flushW,
    output logic        mem_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam int BCW = $clog2(BOOT_FLUSH + 1);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_MWAIT, S_MERR} state_t;

    state_t         r_state, w_state_nxt;
    logic [WCW-1:0] r_wcnt, w_wcnt_nxt, w_wcnt_inc;
    logic [BCW-1:0] r_bcnt, w_bcnt_nxt;

    logic w_mem_stall, w_load_use;
    logic w_hz_bF, w_hz_bD, w_hz_fD, w_hz_fE;
    logic w_bF, w_bD, w_bE, w_bM, w_fD, w_fE, w_fM, w_fW, w_err;

    assign w_mem_stall = mem_req_M & ~mem_ready_M;
    assign w_load_use  = memread_E & (rd_E != 5'd0) &
                         ((use_rs1_D & (rs1_D == rd_E)) | (use_rs2_D & (rs2_D == rd_E)));

    // A taken branch squashes the ID instruction, so it overrides a load-use stall.
    assign w_hz_fD = br_E;
    assign w_hz_fE = br_E | w_load_use;
    assign w_hz_bF = ~br_E & w_load_use;
    assign w_hz_bD = ~br_E & w_load_use;

    assign w_wcnt_inc = r_wcnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_bcnt_nxt  = r_bcnt;
        w_bF = 1'b0; w_bD = 1'b0; w_bE = 1'b0; w_bM = 1'b0;
        w_fD = 1'b0; w_fE = 1'b0; w_fM = 1'b0; w_fW = 1'b0;
        w_err = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_bF = 1'b1;
                w_fD = 1'b1; w_fE = 1'b1; w_fM = 1'b1; w_fW = 1'b1;
                w_bcnt_nxt = r_bcnt + 1'b1;
                if (r_bcnt == BCW'(BOOT_FLUSH - 1)) begin
                    w_state_nxt = S_RUN;
                    w_bcnt_nxt  = '0;
                end
            end
            S_RUN: begin
                if (w_mem_stall) begin
                    w_bF = 1'b1; w_bD = 1'b1; w_bE = 1'b1; w_bM = 1'b1; w_fW = 1'b1;
                    w_wcnt_nxt  = WCW'(1);
                    w_state_nxt = (WCW'(1) == WCW'(MEM_TIMEOUT - 1)) ? S_MERR : S_MWAIT;
                end else begin
                    w_bF = w_hz_bF; w_bD = w_hz_bD; w_fD = w_hz_fD; w_fE = w_hz_fE;
                end
            end
            S_MWAIT: begin
                if (mem_ready_M) begin
                    w_bF = w_hz_bF; w_bD = w_hz_bD; w_fD = w_hz_fD; w_fE = w_hz_fE;
                    w_wcnt_nxt  = '0;
                    w_state_nxt = S_RUN;
                end else begin
                    // wcnt counts stall cycles already taken; the last one before abort is MEM_TIMEOUT-1.
                    w_bF = 1'b1; w_bD = 1'b1; w_bE = 1'b1; w_bM = 1'b1; w_fW = 1'b1;
                    w_wcnt_nxt = w_wcnt_inc;
                    if (w_wcnt_inc == WCW'(MEM_TIMEOUT - 1)) begin
                        w_state_nxt = S_MERR;
                    end
                end
            end
            S_MERR: begin
                w_err = 1'b1;
                w_bF = 1'b1; w_bD = 1'b1; w_bE = 1'b1; w_fM = 1'b1;
                w_wcnt_nxt  = '0;
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
            r_wcnt  <= '0;
            r_bcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_bcnt  <= w_bcnt_nxt;
        end
    end

    assign bubbleF = w_bF;
    assign bubbleD = w_bD;
    assign bubbleE = w_bE;
    assign bubbleM = w_bM;
    assign bubbleW = 1'b0;
    assign flushD  = w_fD;
    assign flushE  = w_fE;
    assign flushM  = w_fM;
    assign flushW  = w_fW;
    assign mem_err = w_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;
    logic        w_br_taken, w_stall_inc;

    assign w_br_taken  = br_E & (((r_state == S_RUN) & ~w_mem_stall) |
                                 ((r_state == S_MWAIT) & mem_ready_M));
    assign w_stall_inc = w_bF & (r_state != S_BOOT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_br_taken)  r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
